// File: rtl/i2c_pkg.sv
// Shared types and sizes for the I2C byte receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;
    localparam int BYTE_BITS = 8;
    localparam int TIMEOUT_W = 16;
    localparam int CNT_W     = $clog2(BYTE_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BITS,
        ST_ACK_WAIT,
        ST_ACK_DRV,
        ST_NACK
    } state_t;
endpackage

// File: rtl/i2c_cond.sv
// Bus condition detector: SCL edges and START/STOP from one-cycle-delayed SCL/SDA.
// Latency: strobes are combinational on the current sample; history is one clk deep.
// Backpressure: none; the bus is sampled every clk.
module i2c_cond
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic scl_q;
    logic sda_q;

    // History resets to an idle bus so reset release cannot look like a START.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_i;
            sda_q <= sda_i;
        end
    end

    assign scl_rise  = scl_i & ~scl_q;
    assign scl_fall  = ~scl_i & scl_q;
    assign start_det = scl_i & scl_q & sda_q & ~sda_i;
    assign stop_det  = scl_i & scl_q & ~sda_q & sda_i;
endmodule

// File: rtl/i2c_byte_rx.sv
// I2C slave byte receiver with ACK/NACK drive; SCL-low timeout under I2C_BYTE_RX_TIMEOUT_EN.
// Latency: start/stop/byte_vld/timeout pulses one clk after the detecting sample.
// Backpressure: none; ack_req is sampled on the SCL fall after the 8th bit.
module i2c_byte_rx
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 scl_i,
    input  logic                 sda_i,
    input  logic                 ack_req,
    output logic                 start_o,
    output logic                 stop_o,
    output logic [BYTE_BITS-1:0] byte_o,
    output logic                 byte_vld_o,
    output logic                 sda_oe_o,
    output logic                 timeout_o
);
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic to_hit;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [BYTE_BITS-2:0] shreg;
    logic                 ninth_rise;

    i2c_cond u_cond (
        .clk       (clk),
        .rstn      (rstn),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

`ifdef I2C_BYTE_RX_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt;

    assign to_hit = ~scl_i && (state != ST_IDLE) &&
                    (to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt <= '0;
        end else if (scl_i || (state == ST_IDLE) || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            ninth_rise <= 1'b0;
            byte_o     <= '0;
            byte_vld_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            sda_oe_o   <= 1'b0;
`ifdef I2C_BYTE_RX_TIMEOUT_EN
            timeout_o  <= 1'b0;
`endif
        end else begin
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            byte_vld_o <= 1'b0;
`ifdef I2C_BYTE_RX_TIMEOUT_EN
            timeout_o  <= 1'b0;
`endif
            // Bus conditions override whatever the bit-level FSM is doing.
            if (start_det) begin
                start_o    <= 1'b1;
                bit_cnt    <= '0;
                shreg      <= '0;
                ninth_rise <= 1'b0;
                sda_oe_o   <= 1'b0;
                state      <= ST_BITS;
            end else if (stop_det) begin
                stop_o   <= 1'b1;
                sda_oe_o <= 1'b0;
                state    <= ST_IDLE;
            end else if (to_hit) begin
`ifdef I2C_BYTE_RX_TIMEOUT_EN
                timeout_o <= 1'b1;
`endif
                sda_oe_o <= 1'b0;
                state    <= ST_IDLE;
            end else begin
                case (state)
                    ST_BITS: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[BYTE_BITS-3:0], sda_i};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_W'(BYTE_BITS - 1)) begin
                                byte_o     <= {shreg, sda_i};
                                byte_vld_o <= 1'b1;
                                state      <= ST_ACK_WAIT;
                            end
                        end
                    end
                    ST_ACK_WAIT: begin
                        if (scl_fall) begin
                            ninth_rise <= 1'b0;
                            sda_oe_o   <= ack_req;
                            state      <= ack_req ? ST_ACK_DRV : ST_NACK;
                        end
                    end
                    ST_ACK_DRV: begin
                        // Hold the ACK through the 9th clock high phase, release on its fall.
                        if (scl_rise) begin
                            ninth_rise <= 1'b1;
                        end else if (scl_fall && ninth_rise) begin
                            ninth_rise <= 1'b0;
                            sda_oe_o   <= 1'b0;
                            bit_cnt    <= '0;
                            state      <= ST_BITS;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_byte_rx.sv
// Directed bench for i2c_byte_rx: bus-level START/bits/ACK/STOP/reset/timeout sequences.
module tb_i2c_byte_rx;
    import i2c_pkg::*;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl_i = 1'b1;
    logic       sda_i = 1'b1;
    logic       ack_req = 1'b0;
    logic       start_o, stop_o, byte_vld_o, sda_oe_o, timeout_o;
    logic [7:0] byte_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start = 0, n_stop = 0, n_vld = 0, n_oe = 0, n_to = 0;
    int b_start = 0, b_stop = 0, b_vld = 0, b_oe = 0, b_to = 0;
    logic [7:0] last_byte = 8'h00;

    i2c_byte_rx #(.TIMEOUT_CYCLES(100)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .ack_req    (ack_req),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .byte_o     (byte_o),
        .byte_vld_o (byte_vld_o),
        .sda_oe_o   (sda_oe_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_o)    n_start++;
        if (stop_o)     n_stop++;
        if (sda_oe_o)   n_oe++;
        if (timeout_o)  n_to++;
        if (byte_vld_o) begin
            n_vld++;
            last_byte = byte_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_start = n_start; b_stop = n_stop; b_vld = n_vld; b_oe = n_oe; b_to = n_to;
    endtask

    task automatic bus_start();
        sda_i = 1'b1; hold(H);
        scl_i = 1'b1; hold(H);
        sda_i = 1'b0; hold(H);
        scl_i = 1'b0; hold(H);
    endtask

    task automatic send_bit(input logic b);
        sda_i = b;    hold(H);
        scl_i = 1'b1; hold(H);
        scl_i = 1'b0; hold(H);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic bus_stop();
        sda_i = 1'b0; hold(H);
        scl_i = 1'b1; hold(H);
        sda_i = 1'b1; hold(H);
    endtask

    initial begin
        logic [7:0] v;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        hold(3);
        check("rst_byte", byte_o, 8'h00);
        check("rst_oe", sda_oe_o, 1'b0);
        check("rst_pulses", {start_o, stop_o, byte_vld_o, timeout_o}, 4'b0000);
        rstn = 1'b1;
        hold(3);
        check("rel_state", dut.state, ST_IDLE);

        // ACK of 0xA0 with exact sda_oe window, then STOP and idle toggling.
        ack_req = 1'b1;
        snap();
        bus_start();
        check("a0_start", n_start - b_start, 1);
        v = 8'hA0;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        sda_i = v[0]; hold(H);
        check("a0_oe_pre", sda_oe_o, 1'b0);
        scl_i = 1'b1; hold(H);
        check("a0_vld", n_vld - b_vld, 1);
        check("a0_byte", byte_o, 8'hA0);
        check("a0_oe_8hi", sda_oe_o, 1'b0);
        scl_i = 1'b0; hold(H);
        check("a0_oe_8fall", sda_oe_o, 1'b1);
        scl_i = 1'b1; hold(H);
        check("a0_oe_9hi", sda_oe_o, 1'b1);
        scl_i = 1'b0; hold(H);
        check("a0_oe_9fall", sda_oe_o, 1'b0);
        check("a0_oe_cycles", n_oe - b_oe, 8);
        check("a0_state", dut.state, ST_BITS);

        snap();
        bus_stop();
        check("stop_pulse", n_stop - b_stop, 1);
        check("stop_oe", sda_oe_o, 1'b0);
        check("stop_state", dut.state, ST_IDLE);
        snap();
        for (int i = 0; i < 6; i++) begin
            scl_i = 1'b0; hold(H);
            sda_i = i[0]; hold(H);
            scl_i = 1'b1; hold(H);
        end
        scl_i = 1'b0; hold(H);
        sda_i = 1'b1; hold(H);
        scl_i = 1'b1; hold(H);
        check("idle_quiet", {n_start - b_start, n_stop - b_stop, n_vld - b_vld, n_oe - b_oe}, 0);
        check("idle_state", dut.state, ST_IDLE);

        // NACK of 0x3C followed by eight more clocks.
        ack_req = 1'b0;
        snap();
        bus_start();
        send_byte(8'h3C);
        check("3c_vld", n_vld - b_vld, 1);
        check("3c_byte", last_byte, 8'h3C);
        for (int i = 0; i < 9; i++) send_bit(i[0]);
        check("3c_vld_after", n_vld - b_vld, 1);
        check("3c_oe_never", n_oe - b_oe, 0);
        check("3c_state", dut.state, ST_NACK);
        check("3c_byte_hold", byte_o, 8'h3C);
        bus_stop();

        // Repeated START after three bits, then 0x5A.
        ack_req = 1'b1;
        snap();
        bus_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        bus_start();
        send_byte(8'h5A);
        check("5a_starts", n_start - b_start, 2);
        check("5a_vld", n_vld - b_vld, 1);
        check("5a_byte", byte_o, 8'h5A);
        send_bit(1'b0);
        bus_stop();

        // Reset mid-byte discards the partial byte.
        bus_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rstn = 1'b0; hold(2);
        check("mid_rst_byte", byte_o, 8'h00);
        check("mid_rst_state", dut.state, ST_IDLE);
        check("mid_rst_oe", sda_oe_o, 1'b0);
        scl_i = 1'b1; sda_i = 1'b1; hold(2);
        rstn = 1'b1; hold(4);
        snap();
        check("post_rst_novld", n_vld - b_vld, 0);
        bus_start();
        v = 8'h01;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        check("01_pre_byte", byte_o, 8'h00);
        check("01_pre_vld", n_vld - b_vld, 0);
        send_bit(v[0]);
        check("01_vld", n_vld - b_vld, 1);
        check("01_byte", byte_o, 8'h01);
        send_bit(1'b0);
        bus_stop();

        // SCL held low after four bits.
        snap();
        bus_start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        hold(150);
`ifdef I2C_BYTE_RX_TIMEOUT_EN
        check("to_pulse", n_to - b_to, 1);
        check("to_state", dut.state, ST_IDLE);
`else
        check("to_pulse", n_to - b_to, 0);
        check("to_state", dut.state, ST_BITS);
`endif
        bus_stop();
        check("to_final_state", dut.state, ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
